// File: rtl/frame_fifo_writer.sv
// Frame-memory to pixel-FIFO write feeder: raster fetch, sof/eol/eof tagging, pulsed FIFO writes.
// Optional FRAME_LOOP_EN: stream frames back-to-back instead of returning to IDLE after eof.
module frame_fifo_writer #(
  parameter int          DATA_WIDTH     = 35,
  parameter int          H_ACTIVE       = 640,
  parameter int          V_ACTIVE       = 480,
  parameter int          MEM_ADDR_WIDTH = 20,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  logic                      clk_wr,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_rd_valid,
  input  logic [DATA_WIDTH-4:0]     mem_rdata,
  input  logic                      fifo_full,
  output logic                      fifo_wren,
  output logic [DATA_WIDTH-1:0]     fifo_data,
  output logic                      fifo_clear,
  output logic                      busy,
  output logic                      done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE = MEM_ADDR_WIDTH'(BASE_ADDR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic                      clear_q, clear_d;
  logic                      last_pix;
  logic                      sof, eol, eof;

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  assign sof      = (x_q == '0) && (y_q == '0);
  assign eol      = (x_q == X_LAST);
  assign eof      = last_pix;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    word_d  = word_q;
    clear_d = 1'b0;
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
      clear_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            clear_d = 1'b1;
            x_d     = '0;
            y_d     = '0;
            addr_d  = BASE;
            state_d = S_REQ;
          end
        end
        // Memory handshake: mem_rd_req/mem_addr hold until the one-cycle
        // mem_rd_valid strobe; data and tags are captured on that strobe.
        S_REQ: begin
          if (mem_rd_valid) begin
            word_d  = {sof, eol, eof, mem_rdata};
            state_d = fifo_full ? S_WAIT : S_WRITE;
          end
        end
        S_WAIT: begin
          if (!fifo_full) state_d = S_WRITE;
        end
        S_WRITE: state_d = S_GAP;
        S_GAP: begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_pix) begin
            x_d = '0;
            y_d = '0;
`ifdef FRAME_LOOP_EN
            addr_d  = BASE;
            state_d = S_REQ;
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      clear_q <= clear_d;
    end
  end

  // abort suppresses request, write and done in the very cycle it is seen.
  assign mem_rd_req = (state_q == S_REQ) && !abort;
  assign mem_addr   = addr_q;
  assign fifo_wren  = (state_q == S_WRITE) && !abort;
  assign fifo_data  = word_q;
  assign fifo_clear = clear_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_GAP) && last_pix && !abort;

endmodule
